hs32_exec: RTL

- Execute stage of the hs32 pipeline, sitting between decode and hs32_lsu.
- Reads operands, resolves hazards against the LSU's l1/l2 stall records, and computes ALU results, which it writes back through its own regfile write port.
- Hands only load/store ops to the LSU as an hs32_s3pkt: res = address, std = store data.

---
 rtl/hs32_pkg.sv | 45 ++++
 rtl/hs32_exec_if.sv | 35 +++
 rtl/hs32_exec_alu.sv | 34 +++
 rtl/hs32_exec.sv | 131 +++++++++++++
 4 files changed

// File: rtl/hs32_pkg.sv
// hs32 shared types: stage packets, LSU stall records, op encoding and the
// hazard-match helper used by the execute stage.
package hs32_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_ASR = 4'd7,
        OP_MOV = 4'd8,
        OP_LDR = 4'd9,
        OP_STR = 4'd10
    } hs32_op_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
    } hs32_s2pkt;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] std;
        logic [3:0]  rd;
        logic        regwe;
        logic        memwe;
    } hs32_s3pkt;

    typedef struct packed {
        logic       vld;
        logic [3:0] rd;
    } hs32_stall;

    function automatic logic hz_match(input hs32_stall rec, input logic [3:0] r);
        return rec.vld && (rec.rd == r);
    endfunction

endpackage

// File: rtl/hs32_exec_if.sv
// Bus bundle around hs32_exec: decode handshake, regfile ports, LSU stall
// records, LSU handshake and ALU write-back. slave = exec, master = its neighbours.
interface hs32_exec_if;
    import hs32_pkg::*;

    logic        valid_i;
    logic        ready_o;
    hs32_s2pkt   data_i;
    logic [3:0]  rp1_addr_o;
    logic [31:0] rp1_data_i;
    logic [3:0]  rp2_addr_o;
    logic [31:0] rp2_data_i;
    hs32_stall   l1_i;
    hs32_stall   l2_i;
    logic [31:0] fwd_i;
    logic        valid_o;
    logic        ready_i;
    hs32_s3pkt   data_o;
    logic [3:0]  wp_addr_o;
    logic [31:0] wp_data_o;
    logic        wp_we_o;

    modport master (
        output valid_i, data_i, rp1_data_i, rp2_data_i, l1_i, l2_i, fwd_i, ready_i,
        input  ready_o, rp1_addr_o, rp2_addr_o, valid_o, data_o,
               wp_addr_o, wp_data_o, wp_we_o
    );

    modport slave (
        input  valid_i, data_i, rp1_data_i, rp2_data_i, l1_i, l2_i, fwd_i, ready_i,
        output ready_o, rp1_addr_o, rp2_addr_o, valid_o, data_o,
               wp_addr_o, wp_data_o, wp_we_o
    );

endinterface

// File: rtl/hs32_exec_alu.sv
// Combinational hs32 ALU; unknown op codes yield zero (the caller never
// writes them back).
module hs32_exec_alu
    import hs32_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic signed [31:0] a_s;
    logic        [4:0]  shamt;

    assign a_s   = $signed(a);
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << shamt;
            OP_SHR:  result = a >> shamt;
            OP_ASR:  result = $unsigned(a_s >>> shamt);
            OP_MOV:  result = b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/hs32_exec.sv
// hs32 execute stage: operand bypass/forwarding, LSU hazard stalls, ALU
// write-back and memory-op hand-off. Optional input skid: HS32_EXEC_SKID_EN.
module hs32_exec
    import hs32_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input logic        clk,
    input logic        resetn,
    hs32_exec_if.slave bus
);

    logic        in_vld;
    hs32_s2pkt   pkt;
    logic        go;
    logic        accept;
    logic        is_alu, is_ldr, is_str, is_mem;
    logic        use1, use2;
    logic        out_blocked;
    logic        stall;
    logic [31:0] src1, src2, opb, alu_res;
    hs32_s3pkt   mem_pkt;

    logic        bp_vld_p1;
    logic [3:0]  bp_rd_p1;
    logic [31:0] bp_val_p1;

`ifdef HS32_EXEC_SKID_EN
    // Skid absorbs the packet offered on the stall cycle so ready_o is registered.
    skid_buffer #(
        .WIDTH($bits(hs32_s2pkt))
    ) u_skid (
        .clk       (clk),
        .rst_n     (resetn),
        .in_valid  (bus.valid_i),
        .in_ready  (bus.ready_o),
        .in_data   (bus.data_i),
        .out_valid (in_vld),
        .out_ready (go),
        .out_data  (pkt)
    );
`else
    assign in_vld      = bus.valid_i;
    assign pkt         = bus.data_i;
    assign bus.ready_o = resetn && go;
`endif

    assign bus.rp1_addr_o = pkt.rs1;
    assign bus.rp2_addr_o = pkt.rs2;

    // Newest ALU result beats LSU load data, which beats the regfile.
    function automatic logic [31:0] pick(
        input logic [3:0]  r,
        input logic [31:0] rf_val,
        input logic        bvld,
        input logic [3:0]  brd,
        input logic [31:0] bval,
        input hs32_stall   l2,
        input logic [31:0] fwd
    );
        if (bvld && (brd == r)) return bval;
        if (hz_match(l2, r))    return fwd;
        return rf_val;
    endfunction

    always_comb begin
        is_alu      = (pkt.op <= OP_MOV);
        is_ldr      = (pkt.op == OP_LDR);
        is_str      = (pkt.op == OP_STR);
        is_mem      = is_ldr || is_str;
        use1        = (is_alu && (pkt.op != OP_MOV)) || is_mem;
        use2        = (is_alu && !pkt.use_imm) || is_str;
        out_blocked = bus.valid_o && !bus.ready_i;
        stall       = (use1 && hz_match(bus.l1_i, pkt.rs1))
                   || (use2 && hz_match(bus.l1_i, pkt.rs2))
                   || (is_alu && (hz_match(bus.l1_i, pkt.rd) || hz_match(bus.l2_i, pkt.rd)))
                   || (is_mem && out_blocked);
        go          = !stall;
        accept      = in_vld && go;
        src1        = pick(pkt.rs1, bus.rp1_data_i, bp_vld_p1, bp_rd_p1, bp_val_p1,
                           bus.l2_i, bus.fwd_i);
        src2        = pick(pkt.rs2, bus.rp2_data_i, bp_vld_p1, bp_rd_p1, bp_val_p1,
                           bus.l2_i, bus.fwd_i);
        opb         = pkt.use_imm ? pkt.imm : src2;
        mem_pkt       = '0;
        mem_pkt.res   = src1 + pkt.imm;
        mem_pkt.std   = is_str ? src2 : 32'h0;
        mem_pkt.rd    = pkt.rd;
        mem_pkt.regwe = is_ldr;
        mem_pkt.memwe = is_str;
    end

    hs32_exec_alu u_alu (
        .op     (pkt.op),
        .a      (src1),
        .b      (opb),
        .result (alu_res)
    );

    // Stage boundary: accepted op -> write-back port, bypass register, LSU output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.wp_we_o   <= 1'b0;
            bus.wp_addr_o <= '0;
            bus.wp_data_o <= '0;
            bus.valid_o   <= 1'b0;
            bus.data_o    <= '{res: RESET_ADDR, std: 32'h0, rd: 4'h0, regwe: 1'b0, memwe: 1'b0};
            bp_vld_p1     <= 1'b0;
            bp_rd_p1      <= '0;
            bp_val_p1     <= '0;
        end else begin
            bus.wp_we_o <= accept && is_alu;
            if (accept && is_alu) begin
                bus.wp_addr_o <= pkt.rd;
                bus.wp_data_o <= alu_res;
                bp_vld_p1     <= 1'b1;
                bp_rd_p1      <= pkt.rd;
                bp_val_p1     <= alu_res;
            end else if (accept && is_ldr && (bp_rd_p1 == pkt.rd)) begin
                bp_vld_p1 <= 1'b0;
            end
            if (accept && is_mem) begin
                bus.valid_o <= 1'b1;
                bus.data_o  <= mem_pkt;
            end else if (bus.ready_i) begin
                bus.valid_o <= 1'b0;
            end
        end
    end

endmodule
